// File: rtl/mem_ddr_bridge_pkg.sv
// Shared memory-access types for the v850 memory stage: access size, bridge FSM
// states, DDR byte-mask constants and the alignment rule.
package v850_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_WDATA = 3'd2,
    ST_RWAIT = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // Mask bit set means the byte lane is NOT written.
  localparam logic [3:0] MASK_NONE    = 4'b1111;
  localparam logic [3:0] MASK_WORD    = 4'b0000;
  localparam logic [3:0] MASK_HALF_LO = 4'b1100;
  localparam logic [3:0] MASK_HALF_HI = 4'b0011;

  function automatic logic access_bad(input size_e size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: access_bad = 1'b0;
      SZ_HALF: access_bad = addr_lo[0];
      SZ_WORD: access_bad = |addr_lo;
      default: access_bad = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_ddr_bridge_if.sv
// Memory-stage request/response and DDR3 user-port signals of mem_ddr_bridge.
// Signal suffixes are relative to the bridge (slave modport).
interface mem_ddr_bridge_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic [1:0]  req_size_i;
  logic        req_signed_i;
  logic [28:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        ddr_cmd_rdy_i;
  logic        ddr_enable_o;
  logic        ddr_cmd_o;
  logic [28:0] ddr_addr_o;
  logic        ddr_write_rdy_i;
  logic        ddr_write_enable_o;
  logic [31:0] ddr_write_data_o;
  logic [3:0]  ddr_write_mask_o;
  logic        ddr_write_data_end_o;
  logic [31:0] ddr_read_data_i;
  logic        ddr_read_data_valid_i;

  modport slave (
    input  req_valid_i, req_write_i, req_size_i, req_signed_i, req_addr_i, req_wdata_i,
           ddr_cmd_rdy_i, ddr_write_rdy_i, ddr_read_data_i, ddr_read_data_valid_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
           ddr_enable_o, ddr_cmd_o, ddr_addr_o, ddr_write_enable_o,
           ddr_write_data_o, ddr_write_mask_o, ddr_write_data_end_o
  );

  modport master (
    output req_valid_i, req_write_i, req_size_i, req_signed_i, req_addr_i, req_wdata_i,
           ddr_cmd_rdy_i, ddr_write_rdy_i, ddr_read_data_i, ddr_read_data_valid_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
           ddr_enable_o, ddr_cmd_o, ddr_addr_o, ddr_write_enable_o,
           ddr_write_data_o, ddr_write_mask_o, ddr_write_data_end_o
  );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store replication + write mask, load lane
// select + sign/zero extension (little-endian lanes).
module mem_lane_align
  import v850_mem_pkg::*;
(
  input  size_e       size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        signed_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  mask_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b  = rdata_i[{addr_lo_i, 3'b000} +: 8];
    lane_h  = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    wdata_o = wdata_i;
    mask_o  = MASK_NONE;
    rdata_o = rdata_i;
    case (size_i)
      SZ_BYTE: begin
        wdata_o = {4{wdata_i[7:0]}};
        mask_o  = ~(4'b0001 << addr_lo_i);
        rdata_o = {{24{signed_i & lane_b[7]}}, lane_b};
      end
      SZ_HALF: begin
        wdata_o = {2{wdata_i[15:0]}};
        mask_o  = addr_lo_i[1] ? MASK_HALF_HI : MASK_HALF_LO;
        rdata_o = {{16{signed_i & lane_h[15]}}, lane_h};
      end
      SZ_WORD: mask_o = MASK_WORD;
      default: mask_o = MASK_NONE;
    endcase
  end

endmodule

// File: rtl/mem_ddr_bridge.sv
// Memory-stage to DDR3 user-port bridge, one access in flight (IDLE/CMD/WDATA/RWAIT/RESP).
// Define MEM_DDR_BRIDGE_TIMEOUT_EN to bound RWAIT by TIMEOUT_CYCLES (error response, rdata 0).
module mem_ddr_bridge
  import v850_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  mem_ddr_bridge_if.slave  bus
);

  if (TIMEOUT_CYCLES == 0) begin : g_cfg_check
    $error("mem_ddr_bridge: TIMEOUT_CYCLES must be nonzero");
  end

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic        signed_q, signed_d;
  logic        err_q, err_d;
  size_e       size_q, size_d;
  logic [28:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] lane_wdata, lane_rdata;
  logic [3:0]  lane_mask;

`ifdef MEM_DDR_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  mem_lane_align u_align (
    .size_i    (size_q),
    .addr_lo_i (addr_q[1:0]),
    .signed_i  (signed_q),
    .wdata_i   (wdata_q),
    .rdata_i   (bus.ddr_read_data_i),
    .wdata_o   (lane_wdata),
    .mask_o    (lane_mask),
    .rdata_o   (lane_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= SZ_BYTE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
`ifdef MEM_DDR_BRIDGE_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      signed_q <= signed_d;
      err_q    <= err_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
`ifdef MEM_DDR_BRIDGE_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    signed_d = signed_q;
    err_d    = err_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
`ifdef MEM_DDR_BRIDGE_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      ST_IDLE: if (bus.req_valid_i) begin
        write_d  = bus.req_write_i;
        signed_d = bus.req_signed_i;
        size_d   = size_e'(bus.req_size_i);
        addr_d   = bus.req_addr_i;
        wdata_d  = bus.req_wdata_i;
        // Bad accesses answer directly without touching the DDR port.
        err_d    = access_bad(size_e'(bus.req_size_i), bus.req_addr_i[1:0]);
        state_d  = err_d ? ST_RESP : ST_CMD;
      end
      ST_CMD: if (bus.ddr_cmd_rdy_i) begin
        state_d = write_q ? ST_WDATA : ST_RWAIT;
`ifdef MEM_DDR_BRIDGE_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ST_WDATA: if (bus.ddr_write_rdy_i) state_d = ST_RESP;
      ST_RWAIT: begin
        if (bus.ddr_read_data_valid_i) begin
          rdata_d = lane_rdata;
          state_d = ST_RESP;
        end
`ifdef MEM_DDR_BRIDGE_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.req_ready_o          = (state_q == ST_IDLE);
  assign bus.resp_valid_o         = (state_q == ST_RESP);
  assign bus.resp_err_o           = (state_q == ST_RESP) & err_q;
  assign bus.resp_rdata_o         = rdata_q;
  assign bus.ddr_enable_o         = (state_q == ST_CMD);
  assign bus.ddr_cmd_o            = (state_q == ST_CMD) & write_q;
  assign bus.ddr_addr_o           = {addr_q[28:2], 2'b00};
  assign bus.ddr_write_enable_o   = (state_q == ST_WDATA);
  assign bus.ddr_write_data_end_o = (state_q == ST_WDATA);
  assign bus.ddr_write_data_o     = (state_q == ST_WDATA) ? lane_wdata : 32'h0;
  assign bus.ddr_write_mask_o     = (state_q == ST_WDATA) ? lane_mask : 4'h0;

endmodule

// File: tb/tb_mem_ddr_bridge.sv
// Directed bench for mem_ddr_bridge: vector table of single accesses plus
// hand sequences for command backpressure, reset during a read and read timeout.
module tb_mem_ddr_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  mem_ddr_bridge_if bus ();

  mem_ddr_bridge #(.TIMEOUT_CYCLES(255)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [28:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  mask;
    logic [31:0] wdd;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        saw_en, saw_wr, pend, got_resp;
    logic [3:0]  mask_seen;
    logic [31:0] wdata_seen;
    logic [28:0] addr_seen;
    int          lat;

    //           wr  sz     sg    addr       wd            rd            err   rdata         mask     wdd           lat
    vecs[0]  = '{1'b0, 2'b00, 1'b1, 29'h102, 32'h0,        32'h0080_0000, 1'b0, 32'hFFFF_FF80, 4'h0,    32'h0,        3};
    vecs[1]  = '{1'b1, 2'b01, 1'b0, 29'h106, 32'h0000_1234, 32'h0,        1'b0, 32'hFFFF_FF80, 4'b0011, 32'h1234_1234, 3};
    vecs[2]  = '{1'b0, 2'b10, 1'b0, 29'h101, 32'h0,        32'h0,        1'b1, 32'hFFFF_FF80, 4'h0,    32'h0,        1};
    vecs[3]  = '{1'b0, 2'b00, 1'b0, 29'h103, 32'h0,        32'h9A00_0000, 1'b0, 32'h0000_009A, 4'h0,    32'h0,        3};
    vecs[4]  = '{1'b0, 2'b01, 1'b1, 29'h102, 32'h0,        32'h8001_7F00, 1'b0, 32'hFFFF_8001, 4'h0,    32'h0,        3};
    vecs[5]  = '{1'b0, 2'b01, 1'b0, 29'h100, 32'h0,        32'h1234_F00D, 1'b0, 32'h0000_F00D, 4'h0,    32'h0,        3};
    vecs[6]  = '{1'b0, 2'b10, 1'b1, 29'h104, 32'h0,        32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 4'h0,    32'h0,        3};
    vecs[7]  = '{1'b1, 2'b00, 1'b0, 29'h101, 32'h0000_00A5, 32'h0,        1'b0, 32'hDEAD_BEEF, 4'b1101, 32'hA5A5_A5A5, 3};
    vecs[8]  = '{1'b1, 2'b10, 1'b0, 29'h108, 32'hCAFE_F00D, 32'h0,        1'b0, 32'hDEAD_BEEF, 4'b0000, 32'hCAFE_F00D, 3};
    vecs[9]  = '{1'b1, 2'b01, 1'b0, 29'h103, 32'h0000_5555, 32'h0,        1'b1, 32'hDEAD_BEEF, 4'h0,    32'h0,        1};
    vecs[10] = '{1'b0, 2'b11, 1'b0, 29'h100, 32'h0,        32'h1111_1111, 1'b1, 32'hDEAD_BEEF, 4'h0,    32'h0,        1};
    vecs[11] = '{1'b0, 2'b00, 1'b1, 29'h100, 32'h0,        32'h0000_007F, 1'b0, 32'h0000_007F, 4'h0,    32'h0,        3};
    vecs[12] = '{1'b1, 2'b00, 1'b0, 29'h103, 32'h1234_5678, 32'h0,        1'b0, 32'h0000_007F, 4'b0111, 32'h7878_7878, 3};

    bus.req_valid_i = 0; bus.req_write_i = 0; bus.req_size_i = 0; bus.req_signed_i = 0;
    bus.req_addr_i = 0; bus.req_wdata_i = 0; bus.ddr_cmd_rdy_i = 1; bus.ddr_write_rdy_i = 1;
    bus.ddr_read_data_i = 0; bus.ddr_read_data_valid_i = 0;

    tick(); tick();
    chk("reset_ready", {31'd0, bus.req_ready_o}, 32'd1);
    chk("reset_resp", {30'd0, bus.resp_valid_o, bus.resp_err_o}, 32'd0);
    chk("reset_rdata", bus.resp_rdata_o, 32'd0);
    chk("reset_ddr", {bus.ddr_enable_o, bus.ddr_cmd_o, bus.ddr_write_enable_o,
                      bus.ddr_write_data_end_o, bus.ddr_write_mask_o, 3'd0, bus.ddr_addr_o},
        32'd0);
    chk("reset_wdata", bus.ddr_write_data_o, 32'd0);
    @(negedge clk) rst = 1'b0;
    tick();

    for (int v = 0; v < 13; v++) begin
      bus.req_valid_i = 1; bus.req_write_i = vecs[v].wr; bus.req_size_i = vecs[v].sz;
      bus.req_signed_i = vecs[v].sg; bus.req_addr_i = vecs[v].addr; bus.req_wdata_i = vecs[v].wd;
      chk($sformatf("v%0d_ready", v), {31'd0, bus.req_ready_o}, 32'd1);
      tick();
      bus.req_valid_i = 0;
      saw_en = 0; saw_wr = 0; pend = 0; got_resp = 0; lat = 0;
      mask_seen = 0; wdata_seen = 0; addr_seen = 0;
      for (int c = 1; c <= 20 && !got_resp; c++) begin
        if (c > 1) tick();
        if (bus.ddr_enable_o) begin saw_en = 1; addr_seen = bus.ddr_addr_o; end
        if (bus.ddr_write_enable_o) begin
          saw_wr = 1; mask_seen = bus.ddr_write_mask_o; wdata_seen = bus.ddr_write_data_o;
        end
        if (bus.resp_valid_o) begin
          got_resp = 1; lat = c;
          chk($sformatf("v%0d_err", v), {31'd0, bus.resp_err_o}, {31'd0, vecs[v].err});
          chk($sformatf("v%0d_rdata", v), bus.resp_rdata_o, vecs[v].rdata);
        end
        if (bus.ddr_read_data_valid_i) bus.ddr_read_data_valid_i = 0;
        else if (pend) begin
          bus.ddr_read_data_i = vecs[v].rd; bus.ddr_read_data_valid_i = 1; pend = 0;
        end
        if (bus.ddr_enable_o && !bus.ddr_cmd_o) pend = 1;
      end
      bus.ddr_read_data_valid_i = 0;
      chk($sformatf("v%0d_latency", v), lat, vecs[v].lat);
      chk($sformatf("v%0d_ddr_cmd_seen", v), {31'd0, saw_en}, {31'd0, ~vecs[v].err});
      if (!vecs[v].err)
        chk($sformatf("v%0d_ddr_addr", v), {3'd0, addr_seen}, {3'd0, vecs[v].addr[28:2], 2'b00});
      if (vecs[v].wr && !vecs[v].err) begin
        chk($sformatf("v%0d_wmask", v), {28'd0, mask_seen}, {28'd0, vecs[v].mask});
        chk($sformatf("v%0d_wdata", v), wdata_seen, vecs[v].wdd);
      end else begin
        chk($sformatf("v%0d_no_wbeat", v), {31'd0, saw_wr}, 32'd0);
      end
      tick();
      chk($sformatf("v%0d_resp_one_cycle", v), {30'd0, bus.resp_valid_o, bus.req_ready_o}, 32'd1);
    end

    // Command backpressure: ddr_cmd_rdy_i low for 5 cycles.
    bus.ddr_cmd_rdy_i = 0;
    bus.req_valid_i = 1; bus.req_write_i = 0; bus.req_size_i = 2'b10; bus.req_signed_i = 0;
    bus.req_addr_i = 29'h200;
    tick();
    bus.req_valid_i = 0;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) tick();
      chk($sformatf("bp_c%0d", c),
          {bus.req_ready_o, bus.ddr_enable_o, bus.ddr_cmd_o, 29'(bus.ddr_addr_o)},
          {1'b0, 1'b1, 1'b0, 29'h200});
    end
    bus.ddr_cmd_rdy_i = 1;
    tick();
    chk("bp_cmd_released", {30'd0, bus.ddr_enable_o, bus.req_ready_o}, 32'd0);
    bus.ddr_read_data_i = 32'h0BAD_F00D; bus.ddr_read_data_valid_i = 1;
    tick();
    bus.ddr_read_data_valid_i = 0;
    chk("bp_resp", {31'd0, bus.resp_valid_o}, 32'd1);
    chk("bp_rdata", bus.resp_rdata_o, 32'h0BAD_F00D);
    tick();

    // Reset while waiting for read data, then a late read-valid.
    bus.req_valid_i = 1; bus.req_addr_i = 29'h300; bus.req_size_i = 2'b10;
    tick();
    bus.req_valid_i = 0;
    tick(); tick();
    chk("rst_in_rwait_pre", {30'd0, bus.req_ready_o, bus.ddr_enable_o}, 32'd0);
    rst = 1; #2; rst = 0;
    chk("rst_async_ready", {31'd0, bus.req_ready_o}, 32'd1);
    bus.ddr_read_data_i = 32'h1234_5678; bus.ddr_read_data_valid_i = 1;
    begin
      logic bad;
      bad = 0;
      for (int c = 0; c < 4; c++) begin
        tick();
        if (bus.resp_valid_o || !bus.req_ready_o || bus.ddr_enable_o) bad = 1;
      end
      chk("rst_late_valid_ignored", {31'd0, bad}, 32'd0);
    end
    bus.ddr_read_data_valid_i = 0;
    chk("rst_rdata_cleared", bus.resp_rdata_o, 32'd0);

`ifdef MEM_DDR_BRIDGE_TIMEOUT_EN
    bus.req_valid_i = 1; bus.req_addr_i = 29'h400; bus.req_size_i = 2'b10; bus.req_write_i = 0;
    tick();
    bus.req_valid_i = 0;
    lat = 0;
    for (int c = 1; c <= 400 && lat == 0; c++) begin
      if (c > 1) tick();
      if (bus.resp_valid_o) begin
        lat = c;
        chk("to_err", {31'd0, bus.resp_err_o}, 32'd1);
        chk("to_rdata", bus.resp_rdata_o, 32'd0);
      end
    end
    chk("to_latency", lat, 257);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
